// File: rtl/wait_state_mem.sv
// Multi-cycle data memory responder: latches one request, waits a fixed number
// of cycles, performs a byte-enabled word write or a word read, then pulses ready_o.
module wait_state_mem #(
    parameter int DEPTH_WORDS   = 1024,
    parameter int READ_LATENCY  = 3,
    parameter int WRITE_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_req_i,
    input  logic        write_enable_i,
    input  logic [3:0]  byte_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        ready_o
);

    localparam int IW      = $clog2(DEPTH_WORDS);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    // The counter only ever holds LAT-2, so it needs room for MAX_LAT-2.
    localparam int CW      = (MAX_LAT > 2) ? $clog2(MAX_LAT - 1) : 1;

    localparam int RD_LOAD_I = (READ_LATENCY > 1)  ? READ_LATENCY - 2  : 0;
    localparam int WR_LOAD_I = (WRITE_LATENCY > 1) ? WRITE_LATENCY - 2 : 0;
    localparam logic [CW-1:0] RD_LOAD = RD_LOAD_I[CW-1:0];
    localparam logic [CW-1:0] WR_LOAD = WR_LOAD_I[CW-1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            we_reg;
    logic [3:0]      be_reg;
    logic [IW-1:0]   idx_reg;
    logic [31:0]     wd_reg;
    logic            ready_reg;

    logic            latch_en;
    logic            lat_one;
    logic            access_en;
    logic            acc_we;
    logic [3:0]      acc_be;
    logic [IW-1:0]   acc_idx;
    logic [31:0]     acc_wd;

    // Only the word-index bits of the address select storage; the rest alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:IW+2], addr_i[1:0]};

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        latch_en   = 1'b0;
        access_en  = 1'b0;
        lat_one    = 1'b0;
        acc_we     = we_reg;
        acc_be     = be_reg;
        acc_idx    = idx_reg;
        acc_wd     = wd_reg;

        case (state_reg)
            IDLE: begin
                if (mem_req_i) begin
                    latch_en = 1'b1;
                    // A single-cycle access must use the live inputs, since
                    // the latches only capture them at this same edge.
                    acc_we   = write_enable_i;
                    acc_be   = byte_enable_i;
                    acc_idx  = addr_i[IW+1:2];
                    acc_wd   = write_data_i;
                    lat_one  = write_enable_i ? (WRITE_LATENCY == 1) : (READ_LATENCY == 1);
                    if (lat_one) begin
                        access_en  = 1'b1;
                        state_next = DONE;
                    end else begin
                        cnt_next   = write_enable_i ? WR_LOAD : RD_LOAD;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    access_en  = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            be_reg    <= 4'h0;
            idx_reg   <= '0;
            wd_reg    <= 32'h0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ready_reg <= (state_next == DONE);
            if (latch_en) begin
                we_reg  <= write_enable_i;
                be_reg  <= byte_enable_i;
                idx_reg <= addr_i[IW+1:2];
                wd_reg  <= write_data_i;
            end
        end
    end

    assign ready_o = ready_reg;

    // One byte-wide array per lane keeps byte-enable writes inferable as RAM.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH_WORDS];
        logic [7:0] rd_lane_reg;

        always_ff @(posedge clk_i) begin
            if (access_en && acc_we && acc_be[gi]) begin
                lane_mem[acc_idx] <= acc_wd[8*gi +: 8];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_lane_reg <= 8'h00;
            end else if (access_en && !acc_we) begin
                rd_lane_reg <= lane_mem[acc_idx];
            end
        end

        assign read_data_o[8*gi +: 8] = rd_lane_reg;
    end

endmodule

// File: tb/tb_wait_state_mem.sv
// Self-checking bench for wait_state_mem: five instances with different depth and
// latency settings, scoreboard queue of expected completions per transaction.
module tb_wait_state_mem;

    localparam int NI = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NI-1:0]   req;
    logic            we;
    logic [3:0]      be;
    logic [31:0]     addr;
    logic [31:0]     wd;
    logic [31:0]     rd [NI];
    logic [NI-1:0]   rdy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          lat;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        w;
        logic [3:0]  b;
        logic [31:0] a;
        logic [31:0] d;
        logic        chk;
        logic [31:0] x;
    } op_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // u0 default, u1 16 words R3/W4, u2 R1/W1, u3 R1/W5, u4 R7/W1
    wait_state_mem #(.DEPTH_WORDS(1024), .READ_LATENCY(3), .WRITE_LATENCY(2)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req[0]), .write_enable_i(we),
        .byte_enable_i(be), .addr_i(addr), .write_data_i(wd),
        .read_data_o(rd[0]), .ready_o(rdy[0]));
    wait_state_mem #(.DEPTH_WORDS(16), .READ_LATENCY(3), .WRITE_LATENCY(4)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req[1]), .write_enable_i(we),
        .byte_enable_i(be), .addr_i(addr), .write_data_i(wd),
        .read_data_o(rd[1]), .ready_o(rdy[1]));
    wait_state_mem #(.DEPTH_WORDS(1024), .READ_LATENCY(1), .WRITE_LATENCY(1)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req[2]), .write_enable_i(we),
        .byte_enable_i(be), .addr_i(addr), .write_data_i(wd),
        .read_data_o(rd[2]), .ready_o(rdy[2]));
    wait_state_mem #(.DEPTH_WORDS(1024), .READ_LATENCY(1), .WRITE_LATENCY(5)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req[3]), .write_enable_i(we),
        .byte_enable_i(be), .addr_i(addr), .write_data_i(wd),
        .read_data_o(rd[3]), .ready_o(rdy[3]));
    wait_state_mem #(.DEPTH_WORDS(1024), .READ_LATENCY(7), .WRITE_LATENCY(1)) u4 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req[4]), .write_enable_i(we),
        .byte_enable_i(be), .addr_i(addr), .write_data_i(wd),
        .read_data_o(rd[4]), .ready_o(rdy[4]));

    function automatic int exp_lat(input int k, input logic w);
        case (k)
            0:       return w ? 2 : 3;
            1:       return w ? 4 : 3;
            2:       return 1;
            3:       return w ? 5 : 1;
            default: return w ? 1 : 7;
        endcase
    endfunction

    // Drives one request on instance k and holds it until ready_o; reports the
    // cycle ready_o arrived in, the read data seen with it, and whether ready_o
    // was low in the following cycle.
    task automatic run_txn(input int k, input logic w, input logic [3:0] b,
                           input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] data, output logic low_after);
        @(posedge clk);
        #1;
        we = w; be = b; addr = a; wd = d;
        req[k] = 1'b1;
        lat  = -1;
        data = 32'h0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (rdy[k]) begin
                lat  = n;
                data = rd[k];
                break;
            end
        end
        @(posedge clk);
        #1;
        req[k] = 1'b0;
        @(negedge clk);
        low_after = ~rdy[k];
        $display("txn inst=%0d we=%0b be=%h addr=%h wd=%h -> ready_cycle=%0d rd=%h",
                 k, w, b, a, d, lat, data);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (rdy[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_ready inst=%0d got=%b exp=0", k, rdy[k]);
            end
            checks++;
            if (rd[k] !== 32'h0) begin
                failures++;
                $display("FAIL reset_rdata inst=%0d got=%h exp=00000000", k, rd[k]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_full_word();
        int lat; logic [31:0] d; logic lo; exp_t e;
        sb.push_back(exp_t'{exp_lat(0, 1'b1), 1'b0, 32'h0});
        run_txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, d, lo);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin
            failures++; $display("FAIL full_wr_latency got=%0d exp=%0d", lat, e.lat);
        end
        checks++;
        if (lo !== 1'b1) begin
            failures++; $display("FAIL full_wr_pulse_width ready_next_cycle_low=%b exp=1", lo);
        end
        sb.push_back(exp_t'{exp_lat(0, 1'b0), 1'b1, 32'hDEADBEEF});
        run_txn(0, 1'b0, 4'h0, 32'h10, 32'h0, lat, d, lo);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin
            failures++; $display("FAIL full_rd_latency got=%0d exp=%0d", lat, e.lat);
        end
        checks++;
        if (d !== e.data) begin
            failures++; $display("FAIL full_rd_data got=%h exp=%h", d, e.data);
        end
        checks++;
        if (lo !== 1'b1) begin
            failures++; $display("FAIL full_rd_pulse_width ready_next_cycle_low=%b exp=1", lo);
        end
    endtask

    task automatic test_byte_lanes();
        int lat; logic [31:0] d; logic lo; exp_t e; op_t ops[5];
        ops[0] = op_t'{1'b1, 4'hF, 32'h20, 32'h11223344, 1'b0, 32'h0};
        ops[1] = op_t'{1'b1, 4'h5, 32'h20, 32'hAABBCCDD, 1'b0, 32'h0};
        ops[2] = op_t'{1'b0, 4'h0, 32'h20, 32'h0,        1'b1, 32'h11BB33DD};
        ops[3] = op_t'{1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 1'b0, 32'h0};
        ops[4] = op_t'{1'b0, 4'h0, 32'h20, 32'h0,        1'b1, 32'h11BB33DD};
        for (int i = 0; i < 5; i++) begin
            sb.push_back(exp_t'{exp_lat(0, ops[i].w), ops[i].chk, ops[i].x});
            run_txn(0, ops[i].w, ops[i].b, ops[i].a, ops[i].d, lat, d, lo);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat) begin
                failures++; $display("FAIL lanes_latency op=%0d got=%0d exp=%0d", i, lat, e.lat);
            end
            checks++;
            if (lo !== 1'b1) begin
                failures++; $display("FAIL lanes_pulse_width op=%0d ready_next_cycle_low=%b exp=1", i, lo);
            end
            if (e.chk) begin
                checks++;
                if (d !== e.data) begin
                    failures++; $display("FAIL lanes_data op=%0d got=%h exp=%h", i, d, e.data);
                end
            end
        end
    endtask

    task automatic test_aliasing();
        int lat; logic [31:0] d; logic lo; exp_t e; op_t ops[3];
        ops[0] = op_t'{1'b1, 4'hF, 32'h04, 32'h5, 1'b0, 32'h0};
        ops[1] = op_t'{1'b0, 4'h0, 32'h44, 32'h0, 1'b1, 32'h5};
        ops[2] = op_t'{1'b0, 4'h0, 32'h06, 32'h0, 1'b1, 32'h5};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(exp_t'{exp_lat(1, ops[i].w), ops[i].chk, ops[i].x});
            run_txn(1, ops[i].w, ops[i].b, ops[i].a, ops[i].d, lat, d, lo);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat) begin
                failures++; $display("FAIL alias_latency op=%0d got=%0d exp=%0d", i, lat, e.lat);
            end
            if (e.chk) begin
                checks++;
                if (d !== e.data) begin
                    failures++; $display("FAIL alias_data op=%0d got=%h exp=%h", i, d, e.data);
                end
            end
        end
    endtask

    task automatic test_held_request();
        exp_t e;
        int   pulses = 0;
        @(posedge clk);
        #1;
        we = 1'b0; be = 4'h0; addr = 32'h10; wd = 32'h0;
        req[0] = 1'b1;
        // Latency 3 plus one DONE cycle: pulses in cycles 3, 7, 11, 15, 19.
        for (int c = 0; c < 20; c++) begin
            sb.push_back(exp_t'{c, ((c % 4) == 3), 32'hDEADBEEF});
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (rdy[0] !== e.chk) begin
                failures++; $display("FAIL held_ready cycle=%0d got=%b exp=%b", e.lat, rdy[0], e.chk);
            end
            if (rdy[0] === 1'b1) begin
                pulses++;
                checks++;
                if (rd[0] !== e.data) begin
                    failures++; $display("FAIL held_data cycle=%0d got=%h exp=%h", e.lat, rd[0], e.data);
                end
            end
        end
        @(posedge clk);
        #1;
        req[0] = 1'b0;
        $display("held request: %0d ready pulses in 20 cycles", pulses);
    endtask

    task automatic test_reset_mid_wait();
        int lat; logic [31:0] d; logic lo; exp_t e;
        int   stray = 0;
        sb.push_back(exp_t'{exp_lat(1, 1'b1), 1'b0, 32'h0});
        run_txn(1, 1'b1, 4'hF, 32'h30, 32'h01234567, lat, d, lo);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin
            failures++; $display("FAIL rstwait_preload_latency got=%0d exp=%0d", lat, e.lat);
        end
        sb.push_back(exp_t'{exp_lat(1, 1'b0), 1'b1, 32'h01234567});
        run_txn(1, 1'b0, 4'h0, 32'h30, 32'h0, lat, d, lo);
        e = sb.pop_front();
        checks++;
        if (d !== e.data) begin
            failures++; $display("FAIL rstwait_preload_data got=%h exp=%h", d, e.data);
        end

        @(posedge clk);
        #1;
        we = 1'b1; be = 4'hF; addr = 32'h30; wd = 32'hCAFEF00D;
        req[1] = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdy[1] !== 1'b0) begin
            failures++; $display("FAIL rstwait_ready got=%b exp=0", rdy[1]);
        end
        checks++;
        if (rd[1] !== 32'h0) begin
            failures++; $display("FAIL rstwait_rdata got=%h exp=00000000", rd[1]);
        end
        req[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rdy[1] !== 1'b0) stray++;
        end
        checks++;
        if (stray !== 0) begin
            failures++; $display("FAIL rstwait_stray_ready got=%0d exp=0", stray);
        end

        sb.push_back(exp_t'{exp_lat(1, 1'b0), 1'b1, 32'h01234567});
        run_txn(1, 1'b0, 4'h0, 32'h30, 32'h0, lat, d, lo);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin
            failures++; $display("FAIL rstwait_read_latency got=%0d exp=%0d", lat, e.lat);
        end
        checks++;
        if (d !== e.data) begin
            failures++; $display("FAIL rstwait_old_contents got=%h exp=%h", d, e.data);
        end
    endtask

    task automatic test_latency_sweep();
        int lat; logic [31:0] d; logic lo; exp_t e;
        logic [31:0] val;
        for (int k = 2; k < NI; k++) begin
            val = 32'hA5A50000 | 32'(k);
            sb.push_back(exp_t'{exp_lat(k, 1'b1), 1'b0, 32'h0});
            run_txn(k, 1'b1, 4'hF, 32'h10, val, lat, d, lo);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat) begin
                failures++; $display("FAIL sweep_wr_latency inst=%0d got=%0d exp=%0d", k, lat, e.lat);
            end
            checks++;
            if (lo !== 1'b1) begin
                failures++; $display("FAIL sweep_wr_pulse_width inst=%0d ready_next_cycle_low=%b exp=1", k, lo);
            end
            sb.push_back(exp_t'{exp_lat(k, 1'b0), 1'b1, val});
            run_txn(k, 1'b0, 4'h0, 32'h10, 32'h0, lat, d, lo);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat) begin
                failures++; $display("FAIL sweep_rd_latency inst=%0d got=%0d exp=%0d", k, lat, e.lat);
            end
            checks++;
            if (d !== e.data) begin
                failures++; $display("FAIL sweep_rd_data inst=%0d got=%h exp=%h", k, d, e.data);
            end
            checks++;
            if (lo !== 1'b1) begin
                failures++; $display("FAIL sweep_rd_pulse_width inst=%0d ready_next_cycle_low=%b exp=1", k, lo);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        req  = '0;
        we   = 1'b0;
        be   = 4'h0;
        addr = 32'h0;
        wd   = 32'h0;
        test_reset();
        test_full_word();
        test_byte_lanes();
        test_aliasing();
        test_held_request();
        test_reset_mid_wait();
        test_latency_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
